// File: rtl/regfile_dump.sv
// Debug readout engine: walks the register bank two registers per fetch and streams
// each value out over valid/ready, tagged with its index. Optional: REGDUMP_SKIP_X0_EN.
module regfile_dump #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rf_a1,
    output logic [AW-1:0] rf_a2,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [AW-1:0] m_addr,
    output logic          m_last
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_SEND_LO = 3'd2,
        S_SEND_HI = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] lo_q, lo_d;
    logic [DW-1:0] hi_q, hi_d;

    logic [AW-1:0] idx_plus1;
    logic          last_pair;
    logic          handshake;
    logic          first_pair;

    assign idx_plus1  = idx_q + AW'(1);
    assign last_pair  = (idx_q == AW'(NREGS - 2));
    assign handshake  = m_valid & m_ready;
    assign first_pair = (idx_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // The pair is snapshotted here; later bank writes cannot reach it.
                lo_d = rf_rd1;
                hi_d = rf_rd2;
`ifdef REGDUMP_SKIP_X0_EN
                state_d = first_pair ? S_SEND_HI : S_SEND_LO;
`else
                state_d = S_SEND_LO;
`endif
            end
            S_SEND_LO: begin
                if (handshake) begin
                    state_d = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                if (handshake) begin
                    if (last_pair) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + AW'(2);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: everything is decoded from state so idle outputs are exactly zero.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        rf_a1   = '0;
        rf_a2   = '0;
        m_valid = 1'b0;
        m_data  = '0;
        m_addr  = '0;
        m_last  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                busy  = 1'b1;
                rf_a1 = idx_q;
                rf_a2 = idx_plus1;
            end
            S_SEND_LO: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                m_data  = lo_q;
                m_addr  = idx_q;
            end
            S_SEND_HI: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                m_data  = hi_q;
                m_addr  = idx_plus1;
                m_last  = last_pair;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

`ifndef REGDUMP_SKIP_X0_EN
    // first_pair only steers the skip path; keep it referenced in the default build.
    logic unused_first_pair;
    assign unused_first_pair = first_pair;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: a bank model feeds the read ports, a reference
// dump list is queued per accepted start, and a monitor pops it on every handshake.
module tb_regfile_dump;

`ifdef REGDUMP_SKIP_X0_EN
    localparam int FIRST = 1;
    localparam int LAT   = 48;
`else
    localparam int FIRST = 0;
    localparam int LAT   = 49;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  rf_a1;
    logic [4:0]  rf_a2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [4:0]  m_addr;
    logic        m_last;

    regfile_dump #(.NREGS(32), .AW(5), .DW(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rf_a1   (rf_a1),
        .rf_a2   (rf_a2),
        .rf_rd1  (rf_rd1),
        .rf_rd2  (rf_rd2),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_addr  (m_addr),
        .m_last  (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank model: register 0 always reads zero.
    logic [31:0] bank [32];
    assign rf_rd1 = (rf_a1 == 5'd0) ? 32'h0 : bank[rf_a1];
    assign rf_rd2 = (rf_a2 == 5'd0) ? 32'h0 : bank[rf_a2];

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } word_t;

    word_t sb[$];
    int    vectors    = 0;
    int    miscompares = 0;
    int    cyc        = 0;
    int    t0         = 0;
    int    done_cnt   = 0;
    int    done_cyc   = 0;
    bit    bp_en      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_dump();
        for (int a = FIRST; a < 32; a++) begin
            word_t w;
            w.addr = a[4:0];
            w.data = (a == 0) ? 32'h0 : bank[a];
            w.last = (a == 31);
            sb.push_back(w);
        end
    endfunction

    // Sink: ready held high, or toggled at random when backpressure is enabled.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor
    bit          stalled = 0;
    logic [31:0] hold_data;
    logic [4:0]  hold_addr;
    logic        hold_last;
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stalled = 0;
        end else begin
            if (stalled) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_data", 64'(m_data), 64'(hold_data));
                chk("stall_addr", 64'(m_addr), 64'(hold_addr));
                chk("stall_last", 64'(m_last), 64'(hold_last));
            end
            if (m_valid) begin
                if (m_ready) begin
                    stalled = 0;
                    if (sb.size() == 0) begin
                        miscompares++;
                        vectors++;
                        $display("FAIL unexpected_word: got addr %0d data 0x%0h, required none", m_addr, m_data);
                    end else begin
                        word_t e;
                        e = sb.pop_front();
                        $display("word addr=%0d data=0x%08h last=%0b", m_addr, m_data, m_last);
                        chk("word_addr", 64'(m_addr), 64'(e.addr));
                        chk("word_data", 64'(m_data), 64'(e.data));
                        chk("word_last", 64'(m_last), 64'(e.last));
                    end
                end else begin
                    stalled   = 1;
                    hold_data = m_data;
                    hold_addr = m_addr;
                    hold_last = m_last;
                end
            end else begin
                chk("idle_out", {27'd0, m_data, m_addr, m_last}, 64'd0);
            end
            if (!busy) begin
                chk("idle_rf_addr", {54'd0, rf_a1, rf_a2}, 64'd0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Caller is positioned just after a rising edge; start is sampled at the next one.
    task automatic issue_start();
        start = 1'b1;
        t0    = cyc;
        push_dump();
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_t1", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        chk("first_valid_t2", 64'(m_valid), 64'd1);
        chk("first_addr_t2", 64'(m_addr), 64'(FIRST));
    endtask

    task automatic start_dump();
        @(posedge clk);
        #1;
        issue_start();
    endtask

    task automatic wait_done(input bit chk_lat);
        int dc;
        int n;
        dc = done_cnt;
        n  = 0;
        while (done_cnt == dc && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == dc) begin
            miscompares++;
            vectors++;
            $display("FAIL done_timeout: got no done in %0d cycles, required a done pulse", n);
        end else begin
            if (chk_lat) chk("done_latency", 64'(done_cyc - t0), 64'(LAT));
            chk("busy_at_done", 64'(busy), 64'd0);
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("dump complete: t0=%0d done_cycle=%0d", t0, done_cyc);
    endtask

    task automatic find_valid_addr(input logic [4:0] a, output bit found);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            if (m_valid && m_addr == a) found = 1;
        end
        if (!found) begin
            miscompares++;
            vectors++;
            $display("FAIL find_addr: got no valid word for addr %0d, required one", a);
        end
    endtask

    initial begin
        bit found;
        int dc0;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 32; i++) bank[i] = 32'hA500_0000 + 32'(i);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);

        // Full dump, sink always ready
        start_dump();
        wait_done(1);

        // Random backpressure, same content
        bp_en = 1;
        start_dump();
        wait_done(0);
        bp_en = 0;
        @(posedge clk);
        #1;

        // Start while busy: pulses at t+10 and t+LAT are ignored, t+LAT+1 starts again
        dc0 = done_cnt;
        start_dump();
        wait_until(t0 + 10);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_until(t0 + LAT);
        chk("done_at_lat", 64'(done), 64'd1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("one_done", 64'(done_cnt - dc0), 64'd1);
        chk("one_dump", 64'(sb.size()), 64'd0);
        issue_start();
        wait_done(1);

        // Reset during SEND_HI of addr 7
        start_dump();
        find_valid_addr(5'd7, found);
        dc0 = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out", {20'd0, m_valid, m_last, m_data, m_addr, busy, done}, 64'd0);
        chk("midrst_rf", {54'd0, rf_a1, rf_a2}, 64'd0);
        repeat (5) @(negedge clk);
        chk("midrst_no_done", 64'(done_cnt - dc0), 64'd0);
        start_dump();
        wait_done(1);

        // Snapshot: write reg 9 while addr 8 is on the bus
        start_dump();
        find_valid_addr(5'd8, found);
        bank[9] = 32'hDEAD_BEEF;
        wait_done(1);
        start_dump();
        wait_done(1);

        // Random bank contents under random backpressure
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i < 32; i++) bank[i] = $urandom;
            bp_en = 1;
            start_dump();
            wait_done(0);
            bp_en = 0;
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug readout engine that acts as the read-side initiator for the 32×32 register bank. On a start pulse it walks every register address by driving both combinational read ports, two registers per fetch. It captures each pair and streams the values out one word at a time over a valid/ready interface, tagged with the register address. It sits beside the datapath register bank and feeds a trace/debug sink, so register state can be dumped without disturbing the write port.

## Interface
- `NREGS`, 32: registers to dump; must be even, 2..32.
- `AW`, 5: register address width.
- `DW`, 32: register data width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- `busy`  out  1  high in FETCH, SEND_LO, SEND_HI.
- `done`  out  1  one-cycle pulse after the final word is accepted.
- `rf_a1`  out  AW  read address port 1, to the register bank.
- `rf_a2`  out  AW  read address port 2, to the register bank.
- `rf_rd1`  in  DW  combinational read data for `rf_a1`.
- `rf_rd2`  in  DW  combinational read data for `rf_a2`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  sink accepts word.
- `m_data`  out  DW  register value.
- `m_addr`  out  AW  register index of `m_data`.
- `m_last`  out  1  high with the final word of the dump.

## Operation
- The block has five states: IDLE, FETCH, SEND_LO, SEND_HI, DONE. It holds an index register `idx`, which is always even.
- **IDLE:** if `start`=1, set `idx`←0 and go to FETCH. Otherwise stay in IDLE.
- **FETCH:** drive `rf_a1`=`idx` and `rf_a2`=`idx+1`. At the clock edge, capture `rf_rd1` into `lo_q` and `rf_rd2` into `hi_q`, then go to SEND_LO.
- **SEND_LO:** drive `m_valid`=1, `m_data`=`lo_q`, `m_addr`=`idx`. On `m_valid`&`m_ready`, go to SEND_HI.
- **SEND_HI:** drive `m_valid`=1, `m_data`=`hi_q`, `m_addr`=`idx+1`.
  - `m_last`=1 when `idx`=NREGS-2.
  - On handshake: if last, go to DONE. Otherwise set `idx`←`idx+2` and go to FETCH.
- **DONE:** drive `done`=1, then go to IDLE unconditionally.
- `start` is ignored outside IDLE. A dump in progress is never restarted.
- The captured value is whatever the bank returns. Address 0 reads 0 by bank rule, so the first word is 0.
- Outside FETCH, `rf_a1`/`rf_a2` are 0.
- Outside SEND_*, `m_valid`, `m_data`, `m_addr` and `m_last` are 0.
- Address arithmetic is AW bits. `idx+1` never wraps because NREGS≤32 and is even.

## Timing
- **Reset:** `rst`=1 at an edge forces IDLE, `idx`=0, `lo_q`=`hi_q`=0. All outputs read 0 the following cycle.
- **Reset mid-dump:** the stream aborts with no `m_last` and no `done`.
- **Start latency:** `start` high in cycle t gives FETCH in t+1 (`busy`=1) and the first `m_valid` in t+2.
- **Throughput:** with `m_ready` held high, each pair takes 3 cycles (FETCH, LO, HI).
  - NREGS=32: the last handshake falls in cycle t+48 and `done` in cycle t+49.
  - `busy` is low in t+49, and a new `start` is accepted from t+50 (IDLE).
- **Backpressure:** while `m_valid`=1 and `m_ready`=0, `m_data`, `m_addr` and `m_last` hold stable and the state holds.
  - `m_valid` never drops without a handshake, except on reset.
- **Data snapshot:** values are snapshotted in FETCH. Bank writes after FETCH do not alter the pair already captured.

## Configuration
- **`REGDUMP_SKIP_X0_EN` defined:** the first FETCH still reads the pair 0/1, but the FSM goes directly to SEND_HI.
  - Register 0 is never emitted; the stream has NREGS-1 words, and the first `m_addr` is 1.
  - With `m_ready` high, first `m_valid` is at t+2 with `m_addr`=1, and `done` is at t+48.
- **Not defined:** all NREGS words are emitted, starting with `m_addr`=0, `m_data`=0.

## Test plan
- **Full dump, sink always ready:** preload registers 1..31 with 0xA5000000+i; pulse `start`, hold `m_ready`=1.
  - Expect 32 words, addr 0..31, data 0 then 0xA5000001..0xA500001F.
  - Expect `m_last` only on addr 31 and `done` exactly at t+49.
- **Random backpressure:** toggle `m_ready` pseudo-randomly.
  - Stream content must match the previous scenario.
  - `m_data`/`m_addr` must stay stable across every stall.
  - `m_valid` must never drop before a handshake.
- **Start while busy:** pulse `start` again at t+10 and t+49.
  - Exactly one dump of 32 words and one `done`.
  - A `start` at t+50 begins a second dump.
- **Reset mid-dump:** assert `rst` during the SEND_HI of addr 7.
  - Next cycle: all outputs 0, no `m_last`, no `done`.
  - A new `start` then dumps from addr 0.
- **Snapshot:** write register 9 = 0xDEADBEEF during the SEND_LO of addr 8 (pair 8/9 already fetched).
  - The emitted addr 9 carries the old value.
  - A second dump shows 0xDEADBEEF.
- **`REGDUMP_SKIP_X0_EN` build:** 31 words, addr 1..31, first `m_valid` at t+2, `done` at t+48.
